// File: rtl/buff_mult_arr_ctrl_pkg.sv
// rtl/buff_mult_arr_ctrl_pkg.sv - shared types and sizing for the buffered multiplier array sequencer
package buff_mult_arr_ctrl_pkg;

  localparam int BMA_DATA_WID = 8;
  localparam int BMA_ADDR_B   = 4;
  localparam int BMA_MUL_NUM  = 4;
  localparam int BMA_ROUND_B  = 8;
  localparam int BMA_PIPE_LAT = 3;
  localparam int BMA_LANE_B   = (BMA_MUL_NUM > 1) ? $clog2(BMA_MUL_NUM) : 1;

  typedef enum logic {
    INVALID = 1'b0,
    COMPUTE = 1'b1
  } PE_STATE;

  typedef enum logic [1:0] {
    BMA_ST_IDLE,
    BMA_ST_LOAD,
    BMA_ST_COMPUTE,
    BMA_ST_DRAIN
  } bma_state_e;

  typedef struct packed {
    logic [BMA_MUL_NUM-1:0]              wrb;
    logic [BMA_ADDR_B-1:0]               wrb_addr;
    logic [BMA_DATA_WID-1:0]             wrb_data;
    logic [BMA_ADDR_B-1:0]               rdb_addr;
    logic [BMA_MUL_NUM*BMA_DATA_WID-1:0] A;
    PE_STATE                             PE_state;
  } PE_IN_PACKET;

  function automatic logic [BMA_MUL_NUM-1:0] lane_onehot(input logic [BMA_LANE_B-1:0] lane);
    return BMA_MUL_NUM'(1) << lane;
  endfunction

endpackage

// File: rtl/buff_mult_arr_ctrl_if.sv
// rtl/buff_mult_arr_ctrl_if.sv - job, weight, activation and array-drive signals of the sequencer
interface buff_mult_arr_ctrl_if;
  import buff_mult_arr_ctrl_pkg::*;

  logic                                cfg_valid;
  logic                                cfg_ready;
  logic [BMA_ADDR_B:0]                 cfg_depth;
  logic [BMA_ROUND_B-1:0]              cfg_rounds;
  logic                                abort;
  logic                                w_valid;
  logic                                w_ready;
  logic [BMA_DATA_WID-1:0]             w_data;
  logic                                a_valid;
  logic                                a_ready;
  logic [BMA_MUL_NUM*BMA_DATA_WID-1:0] a_data;
  PE_IN_PACKET                         pe_in_pk;
  logic                                busy;
  logic                                done;
  logic                                aborted;

  modport master (
    output cfg_valid, cfg_depth, cfg_rounds, abort, w_valid, w_data, a_valid, a_data,
    input  cfg_ready, w_ready, a_ready, pe_in_pk, busy, done, aborted
  );

  modport slave (
    input  cfg_valid, cfg_depth, cfg_rounds, abort, w_valid, w_data, a_valid, a_data,
    output cfg_ready, w_ready, a_ready, pe_in_pk, busy, done, aborted
  );

endinterface

// File: rtl/bma_ctrl_cnt.sv
// rtl/bma_ctrl_cnt.sv - lane/addr/round nested counter with terminal flags
module bma_ctrl_cnt
  import buff_mult_arr_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   inc_i,
  input  logic                   load_mode_i,
  input  logic [BMA_ADDR_B:0]    depth_i,
  input  logic [BMA_ROUND_B-1:0] rounds_i,
  output logic [BMA_LANE_B-1:0]  lane_o,
  output logic [BMA_ADDR_B-1:0]  addr_o,
  output logic                   addr_last_o,
  output logic                   lane_last_o,
  output logic                   round_last_o
);

  logic [BMA_LANE_B-1:0]  lane_q, lane_d;
  logic [BMA_ADDR_B:0]    addr_q, addr_d;
  logic [BMA_ROUND_B-1:0] round_q, round_d;

  assign addr_last_o  = (addr_q == depth_i - (BMA_ADDR_B+1)'(1));
  assign lane_last_o  = (lane_q == BMA_LANE_B'(BMA_MUL_NUM - 1));
  assign round_last_o = (round_q == rounds_i - BMA_ROUND_B'(1));
  assign lane_o       = lane_q;
  assign addr_o       = addr_q[BMA_ADDR_B-1:0];

  // addr is the inner loop; the outer index (lane in LOAD, round in COMPUTE) sticks at its terminal value
  always_comb begin
    lane_d  = lane_q;
    addr_d  = addr_q;
    round_d = round_q;
    if (clr_i) begin
      lane_d  = '0;
      addr_d  = '0;
      round_d = '0;
    end else if (inc_i) begin
      if (addr_last_o) begin
        addr_d = '0;
        if (load_mode_i && !lane_last_o)
          lane_d = lane_q + BMA_LANE_B'(1);
        if (!load_mode_i && !round_last_o)
          round_d = round_q + BMA_ROUND_B'(1);
      end else begin
        addr_d = addr_q + (BMA_ADDR_B+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      addr_q  <= '0;
      round_q <= '0;
    end else begin
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/buff_mult_arr_ctrl.sv
// rtl/buff_mult_arr_ctrl.sv - load/replay/drain sequencer driving the multiplier array packet
// Optional BMA_CTRL_PERF_EN adds stall_cnt and job_cyc counters.
module buff_mult_arr_ctrl
  import buff_mult_arr_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = BMA_PIPE_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  buff_mult_arr_ctrl_if.slave  bus
`ifdef BMA_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          job_cyc
`endif
);

  localparam int DRN_B = $clog2(PIPE_LAT + 1);

  bma_state_e             state_q, state_d;
  logic [BMA_ADDR_B:0]    depth_q, depth_d;
  logic [BMA_ROUND_B-1:0] rounds_q, rounds_d;
  logic [DRN_B-1:0]       drain_q, drain_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   abort_seen_q, abort_seen_d;
  PE_IN_PACKET            pe_q, pe_d;

  logic [BMA_LANE_B-1:0]  lane;
  logic [BMA_ADDR_B-1:0]  addr;
  logic                   addr_last, lane_last, round_last;
  logic                   cfg_acc, load_acc, cmp_acc;

  assign cfg_acc  = (state_q == BMA_ST_IDLE) && bus.cfg_valid;
  assign load_acc = (state_q == BMA_ST_LOAD) && bus.w_valid && !bus.abort;
  assign cmp_acc  = (state_q == BMA_ST_COMPUTE) && bus.a_valid && !bus.abort;

  bma_ctrl_cnt u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (cfg_acc),
    .inc_i        (load_acc || cmp_acc),
    .load_mode_i  (state_q == BMA_ST_LOAD),
    .depth_i      (depth_q),
    .rounds_i     (rounds_q),
    .lane_o       (lane),
    .addr_o       (addr),
    .addr_last_o  (addr_last),
    .lane_last_o  (lane_last),
    .round_last_o (round_last)
  );

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    rounds_d     = rounds_q;
    drain_d      = '0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    abort_seen_d = abort_seen_q;
    pe_d          = pe_q;
    pe_d.wrb      = '0;
    pe_d.PE_state = INVALID;
    case (state_q)
      BMA_ST_IDLE: begin
        if (bus.cfg_valid) begin
          depth_d      = bus.cfg_depth;
          rounds_d     = bus.cfg_rounds;
          abort_seen_d = 1'b0;
          state_d      = (bus.cfg_depth == '0 || bus.cfg_rounds == '0) ? BMA_ST_DRAIN : BMA_ST_LOAD;
        end
      end
      BMA_ST_LOAD: begin
        if (bus.abort) begin
          abort_seen_d = 1'b1;
          state_d      = BMA_ST_DRAIN;
        end else if (bus.w_valid) begin
          pe_d.wrb      = lane_onehot(lane);
          pe_d.wrb_addr = addr;
          pe_d.wrb_data = bus.w_data;
          if (lane_last && addr_last)
            state_d = BMA_ST_COMPUTE;
        end
      end
      BMA_ST_COMPUTE: begin
        if (bus.abort) begin
          abort_seen_d = 1'b1;
          state_d      = BMA_ST_DRAIN;
        end else if (bus.a_valid) begin
          pe_d.A        = bus.a_data;
          pe_d.rdb_addr = addr;
          pe_d.PE_state = COMPUTE;
          if (round_last && addr_last)
            state_d = BMA_ST_DRAIN;
        end
      end
      BMA_ST_DRAIN: begin
        // PIPE_LAT invalid cycles let the array flush before done is raised
        if (drain_q == DRN_B'(PIPE_LAT)) begin
          done_d    = 1'b1;
          aborted_d = abort_seen_q;
          state_d   = BMA_ST_IDLE;
        end else begin
          drain_d = drain_q + DRN_B'(1);
        end
      end
      default: state_d = BMA_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BMA_ST_IDLE;
      depth_q      <= '0;
      rounds_q     <= '0;
      drain_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_seen_q <= 1'b0;
      pe_q         <= '0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      rounds_q     <= rounds_d;
      drain_q      <= drain_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_seen_q <= abort_seen_d;
      pe_q         <= pe_d;
    end
  end

  assign bus.cfg_ready = (state_q == BMA_ST_IDLE);
  assign bus.w_ready   = (state_q == BMA_ST_LOAD);
  assign bus.a_ready   = (state_q == BMA_ST_COMPUTE);
  assign bus.busy      = (state_q != BMA_ST_IDLE);
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.pe_in_pk  = pe_q;

`ifdef BMA_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d, job_q, job_d;
  logic        bubble;

  assign bubble = ((state_q == BMA_ST_LOAD) && !bus.w_valid) ||
                  ((state_q == BMA_ST_COMPUTE) && !bus.a_valid);

  always_comb begin
    stall_d = stall_q;
    job_d   = job_q;
    if (cfg_acc) begin
      stall_d = '0;
      job_d   = '0;
    end else begin
      if (bubble && stall_q != '1)
        stall_d = stall_q + 32'd1;
      if (state_q != BMA_ST_IDLE && job_q != '1)
        job_d = job_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      job_q   <= '0;
    end else begin
      stall_q <= stall_d;
      job_q   <= job_d;
    end
  end

  assign stall_cnt = stall_q;
  assign job_cyc   = job_q;
`endif

endmodule

// File: tb/tb_buff_mult_arr_ctrl.sv
// tb/tb_buff_mult_arr_ctrl.sv - randomized self-checking bench for buff_mult_arr_ctrl
module tb_buff_mult_arr_ctrl;
  import buff_mult_arr_ctrl_pkg::*;

  localparam int MUL = BMA_MUL_NUM;
  localparam int DW  = BMA_DATA_WID;
  localparam int AB  = BMA_ADDR_B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  buff_mult_arr_ctrl_if bus();
`ifdef BMA_CTRL_PERF_EN
  logic [31:0] stall_cnt, job_cyc;
`endif

  buff_mult_arr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BMA_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .job_cyc   (job_cyc)
`endif
  );

  typedef struct { logic [MUL-1:0] wrb; int addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [MUL*DW-1:0] a; int addr; } cmp_t;

  wr_t  exp_wr[$], obs_wr[$];
  cmp_t exp_cmp[$], obs_cmp[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_ab = 1'b0;
  logic [AB-1:0] prev_rdb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // advance to the next falling edge and log what the array sees
  task automatic cycle();
    @(negedge clk);
    if (!reset) begin
      vecs++;
      if (bus.w_ready && bus.a_ready) begin
        errs++; $display("FAIL ready_excl: w_ready=%b a_ready=%b required not both 1", bus.w_ready, bus.a_ready);
      end
      if (bus.pe_in_pk.wrb != '0)
        obs_wr.push_back('{bus.pe_in_pk.wrb, int'(bus.pe_in_pk.wrb_addr), bus.pe_in_pk.wrb_data});
      vecs++;
      if (bus.pe_in_pk.PE_state == COMPUTE) begin
        obs_cmp.push_back('{bus.pe_in_pk.A, int'(bus.pe_in_pk.rdb_addr)});
        if (bus.pe_in_pk.wrb !== '0) begin
          errs++; $display("FAIL wrb_in_compute: wrb=%b required 0", bus.pe_in_pk.wrb);
        end
      end else if (bus.pe_in_pk.rdb_addr !== prev_rdb) begin
        errs++; $display("FAIL rdb_hold: rdb_addr=%0d required %0d", bus.pe_in_pk.rdb_addr, prev_rdb);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_ab  = bus.aborted;
      end else begin
        vecs++;
        if (bus.aborted !== 1'b0) begin
          errs++; $display("FAIL aborted_no_done: aborted=%b required 0", bus.aborted);
        end
      end
    end
    prev_rdb = bus.pe_in_pk.rdb_addr;
  endtask

  task automatic drive_idle();
    bus.cfg_valid  = 1'b0;
    bus.cfg_depth  = '0;
    bus.cfg_rounds = '0;
    bus.abort      = 1'b0;
    bus.w_valid    = 1'b0;
    bus.w_data     = '0;
    bus.a_valid    = 1'b0;
    bus.a_data     = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    vecs++;
    if (bus.pe_in_pk !== '0 || bus.w_ready !== 1'b0 || bus.a_ready !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s: pe=%h wr=%b ar=%b busy=%b done=%b ab=%b cfg_rdy=%b required pe=0 0 0 0 0 0 1",
               tag, bus.pe_in_pk, bus.w_ready, bus.a_ready, bus.busy, bus.done, bus.aborted, bus.cfg_ready);
    end
  endtask

  // one job: drive, model the expected packet stream, then compare
  task automatic run_job(input int depth, input int rounds, input int prob, input int a_alt,
                         input int abort_word, input int reset_beat, input string tag);
    int acc_edge, ref_edge, bubbles, sent, total, t;
    bit ab_exp, hit_rst;
    logic [MUL-1:0] oh;
    ab_exp = 0; hit_rst = 0; bubbles = 0;
    exp_wr.delete(); obs_wr.delete(); exp_cmp.delete(); obs_cmp.delete();
    done_cnt = 0;
    vecs++;
    if (bus.cfg_ready !== 1'b1) begin
      errs++; $display("FAIL %s cfg_ready: got %b required 1", tag, bus.cfg_ready);
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_depth  = (AB+1)'(depth);
    bus.cfg_rounds = BMA_ROUND_B'(rounds);
    acc_edge = cyc + 1;
    ref_edge = acc_edge;
    cycle();
    bus.cfg_valid = 1'b0;
    if (depth > 0 && rounds > 0) begin
      total = MUL * depth; sent = 0; t = 0;
      while (sent < total && t < 1000 && !ab_exp) begin
        vecs++;
        if (bus.w_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
          errs++; $display("FAIL %s load_ready: w=%b a=%b required 1 0", tag, bus.w_ready, bus.a_ready);
        end
        bus.cfg_valid  = 1'b1;
        bus.cfg_depth  = (AB+1)'($urandom_range(16));
        bus.w_valid    = ($urandom_range(99) < prob);
        bus.w_data     = DW'($urandom);
        if (!bus.w_valid) bubbles++;
        if (bus.w_valid && sent == abort_word) begin
          bus.abort = 1'b1; ab_exp = 1; ref_edge = cyc + 1;
        end else if (bus.w_valid) begin
          oh = '0; oh[sent / depth] = 1'b1;
          exp_wr.push_back('{oh, sent % depth, bus.w_data});
          sent++;
        end
        cycle(); t++;
      end
      bus.w_valid = 1'b0; bus.abort = 1'b0;
      if (t >= 1000) begin errs++; $display("FAIL %s load_timeout: sent=%0d required %0d", tag, sent, total); end
      total = depth * rounds; sent = 0; t = 0;
      while (!ab_exp && !hit_rst && sent < total && t < 1000) begin
        vecs++;
        if (bus.a_ready !== 1'b1 || bus.w_ready !== 1'b0) begin
          errs++; $display("FAIL %s cmp_ready: a=%b w=%b required 1 0", tag, bus.a_ready, bus.w_ready);
        end
        if (sent == reset_beat) begin
          hit_rst = 1;
          #1 reset = 1'b1;
          #1 check_reset_vals({tag, "_async_rst"});
          drive_idle();
          cycle(); cycle();
          reset = 1'b0;
          vecs++;
          if (done_cnt != 0) begin errs++; $display("FAIL %s rst_done: done pulses=%0d required 0", tag, done_cnt); end
        end else begin
          bus.cfg_valid = 1'b1;
          bus.a_valid   = a_alt ? (t % 2 == 0) : ($urandom_range(99) < prob);
          bus.a_data    = (MUL*DW)'({$urandom, $urandom});
          if (!bus.a_valid) bubbles++;
          if (bus.a_valid) begin
            exp_cmp.push_back('{bus.a_data, sent % depth});
            sent++;
            if (sent == total) ref_edge = cyc + 1;
          end
          cycle(); t++;
        end
      end
      if (t >= 1000) begin errs++; $display("FAIL %s cmp_timeout: sent=%0d required %0d", tag, sent, total); end
    end
    bus.a_valid = 1'b0; bus.cfg_valid = 1'b0;
    if (hit_rst) return;
    t = 0;
    while (done_cnt == 0 && t < 20) begin cycle(); t++; end
    vecs++;
    if (done_cnt != 1) begin
      errs++; $display("FAIL %s done_seen: pulses=%0d required 1", tag, done_cnt);
    end else begin
      vecs++;
      if (done_cyc - ref_edge != 4) begin
        errs++; $display("FAIL %s done_latency: got %0d required 4", tag, done_cyc - ref_edge);
      end
      vecs++;
      if (done_ab !== ab_exp) begin
        errs++; $display("FAIL %s aborted: got %b required %b", tag, done_ab, ab_exp);
      end
`ifdef BMA_CTRL_PERF_EN
      vecs++;
      if (stall_cnt !== 32'(bubbles)) begin
        errs++; $display("FAIL %s stall_cnt: got %0d required %0d", tag, stall_cnt, bubbles);
      end
      vecs++;
      if (job_cyc !== 32'(done_cyc - acc_edge)) begin
        errs++; $display("FAIL %s job_cyc: got %0d required %0d", tag, job_cyc, done_cyc - acc_edge);
      end
`endif
    end
    cycle();
    vecs++;
    if (bus.done !== 1'b0 || done_cnt != 1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errs++; $display("FAIL %s post_done: done=%b pulses=%0d busy=%b cfg_rdy=%b required 0 1 0 1",
                       tag, bus.done, done_cnt, bus.busy, bus.cfg_ready);
    end
    vecs++;
    if (obs_wr.size() != exp_wr.size()) begin
      errs++; $display("FAIL %s wr_count: got %0d required %0d", tag, obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      vecs++;
      if (obs_wr[i].wrb !== exp_wr[i].wrb || obs_wr[i].addr != exp_wr[i].addr || obs_wr[i].data !== exp_wr[i].data) begin
        errs++; $display("FAIL %s wr[%0d]: got wrb=%b addr=%0d data=%h required wrb=%b addr=%0d data=%h", tag, i,
                         obs_wr[i].wrb, obs_wr[i].addr, obs_wr[i].data, exp_wr[i].wrb, exp_wr[i].addr, exp_wr[i].data);
      end
    end
    vecs++;
    if (obs_cmp.size() != exp_cmp.size()) begin
      errs++; $display("FAIL %s cmp_count: got %0d required %0d", tag, obs_cmp.size(), exp_cmp.size());
    end
    for (int i = 0; i < exp_cmp.size() && i < obs_cmp.size(); i++) begin
      vecs++;
      if (obs_cmp[i].a !== exp_cmp[i].a || obs_cmp[i].addr != exp_cmp[i].addr) begin
        errs++; $display("FAIL %s cmp[%0d]: got A=%h addr=%0d required A=%h addr=%0d", tag, i,
                         obs_cmp[i].a, obs_cmp[i].addr, exp_cmp[i].a, exp_cmp[i].addr);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b0;
    cycle();
    check_reset_vals("reset_released");
  endtask

  task automatic test_basic();
    run_job(3, 2, 100, 0, -1, -1, "basic");
  endtask

  task automatic test_bubbles();
    run_job(3, 2, 100, 1, -1, -1, "bubbles");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++)
      run_job($urandom_range(16, 1), $urandom_range(3, 1), 60, 0, -1, -1, "random");
  endtask

  task automatic test_zero();
    run_job(0, 2, 100, 0, -1, -1, "zero_depth");
    run_job(3, 0, 100, 0, -1, -1, "zero_rounds");
  endtask

  task automatic test_depth16();
    run_job(16, 1, 100, 0, -1, -1, "depth16");
  endtask

  task automatic test_abort();
    run_job(3, 2, 100, 0, 4, -1, "abort");
  endtask

  task automatic test_reset_mid();
    run_job(2, 3, 100, 0, -1, 2, "reset_mid");
    run_job(2, 2, 80, 0, -1, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_random();
    test_zero();
    test_depth16();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
